// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Autonomous 4x4 active-low keypad scanner behind an Avalon-MM slave.
//   It drives one column low at a time and samples the synchronized rows.
//   A full-matrix snapshot is accepted after DEBOUNCE identical scans.
//   Newly pressed keys are queued as 4-bit codes {row, col} in a FIFO.
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   address[1:0]            register select: 0 DATA, 1 STATUS, 2 CONTROL, 3 reserved
//   chipselect, write_n,    zero-wait-state slave strobes; a DATA read pops the FIFO
//   read_n, writedata[7:0]
//   readdata[7:0]           combinational register read mux
//   row_in[3:0]             keypad rows (async, active-low, pulled up)
//   col_out[3:0]            keypad columns, one driven low while scanning
//   irq                     level interrupt: irq_en & FIFO non-empty
//
// state | meaning
// IDLE  | scanning disabled, all columns released
// SCAN  | one column driven low; rows sampled at the end of each column step
// CMP   | one cycle: compare snapshot to previous scan and update debounce
// EMIT  | 16 cycles: push the code of each newly pressed key, in code order
module keypad_scan_ctrl #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic       read_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       irq
);
  localparam int STEP_W = $clog2(SCAN_DIV);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_CMP, ST_EMIT} state_t;

  state_t            state_q;
  logic [3:0]        row_s1_q, row_s2_q;
  logic              scan_en_q, irq_en_q, ovf_q;
  logic [1:0]        col_q;
  logic [STEP_W-1:0] step_q;
  logic [3:0]        stable_q;
  logic [15:0]       snap_q, prev_q, acc_q, new_mask_q;
  logic [3:0]        emit_q;
  logic [3:0]        col_out_q;
  logic [3:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic        wr_en, rd_en, fifo_empty, fifo_full;
  logic        pop, flush, push_req, push_ok;
  logic        snap_eq, accept;
  logic [3:0]  stable_d;
  logic [15:0] new_mask_d;
  logic [2:0]  cnt_sat;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[7:3];

  assign wr_en      = chipselect & ~write_n;
  assign rd_en      = chipselect & ~read_n;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = rd_en & (address == 2'd0) & ~fifo_empty;
  assign flush      = wr_en & (address == 2'd2) & writedata[2];

  // Snapshot bit index is col*4+row while the emitted code is row*4+col,
  // so the EMIT index is transposed when selecting the mask bit.
  assign push_req = (state_q == ST_EMIT) & new_mask_q[{emit_q[1:0], emit_q[3:2]}];
  assign push_ok  = push_req & (~fifo_full | pop);

  assign snap_eq    = (snap_q == prev_q);
  assign stable_d   = !snap_eq ? 4'd0 : ((stable_q == 4'hF) ? stable_q : stable_q + 4'd1);
  assign accept     = snap_eq & (stable_d >= 4'(DEBOUNCE - 1));
  assign new_mask_d = snap_q & ~acc_q;

  assign col_out = col_out_q;
  assign irq     = irq_en_q & ~fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= row_in;
      row_s2_q <= row_s1_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      col_q      <= 2'd0;
      step_q     <= '0;
      stable_q   <= 4'd0;
      snap_q     <= 16'h0;
      prev_q     <= 16'h0;
      acc_q      <= 16'h0;
      new_mask_q <= 16'h0;
      emit_q     <= 4'd0;
      col_out_q  <= 4'b1111;
    end else if (!scan_en_q) begin
      state_q    <= ST_IDLE;
      col_q      <= 2'd0;
      step_q     <= '0;
      stable_q   <= 4'd0;
      snap_q     <= 16'h0;
      prev_q     <= 16'h0;
      acc_q      <= 16'h0;
      new_mask_q <= 16'h0;
      emit_q     <= 4'd0;
      col_out_q  <= 4'b1111;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q   <= ST_SCAN;
          col_q     <= 2'd0;
          step_q    <= STEP_W'(SCAN_DIV - 1);
          col_out_q <= 4'b1110;
        end
        ST_SCAN: begin
          // Down-counter; terminal count 0 is the last cycle of a column.
          if (step_q == '0) begin
            snap_q[{col_q, 2'b00} +: 4] <= ~row_s2_q;
            if (col_q == 2'd3) begin
              state_q   <= ST_CMP;
              col_q     <= 2'd0;
              col_out_q <= 4'b1111;
            end else begin
              col_q     <= col_q + 2'd1;
              step_q    <= STEP_W'(SCAN_DIV - 1);
              col_out_q <= ~(4'b0001 << (col_q + 2'd1));
            end
          end else begin
            step_q <= step_q - STEP_W'(1);
          end
        end
        ST_CMP: begin
          stable_q   <= stable_d;
          prev_q     <= snap_q;
          new_mask_q <= accept ? new_mask_d : 16'h0;
          if (accept) acc_q <= snap_q;
          if (accept && (new_mask_d != 16'h0)) begin
            state_q <= ST_EMIT;
            emit_q  <= 4'd0;
          end else begin
            state_q   <= ST_SCAN;
            step_q    <= STEP_W'(SCAN_DIV - 1);
            col_out_q <= 4'b1110;
          end
        end
        ST_EMIT: begin
          emit_q <= emit_q + 4'd1;
          if (emit_q == 4'd15) begin
            state_q    <= ST_SCAN;
            new_mask_q <= 16'h0;
            step_q     <= STEP_W'(SCAN_DIV - 1);
            col_out_q  <= 4'b1110;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          col_out_q <= 4'b1111;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_en_q <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (wr_en && address == 2'd2) begin
        scan_en_q <= writedata[0];
        irq_en_q  <= writedata[1];
      end
      // A new drop wins over a simultaneous clear so the event is not lost.
      if (push_req && fifo_full && !pop && !flush) ovf_q <= 1'b1;
      else if (wr_en && address == 2'd1 && writedata[2]) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 4'h0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= emit_q;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  always_comb begin
    cnt_sat = (32'(count_q) > 7) ? 3'd7 : 3'(count_q);
  end

  always_comb begin
    readdata = 8'h00;
    case (address)
      2'd0: if (!fifo_empty) readdata = {1'b1, 3'b000, mem_q[rd_ptr_q]};
      2'd1: readdata = {1'b0, cnt_sat, scan_en_q, ovf_q, fifo_full, ~fifo_empty};
      2'd2: readdata = {6'b0, irq_en_q, scan_en_q};
      default: readdata = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4.
// A behavioural keypad pulls a row low when its column is driven low and the
// key at {row, col} is held in 'keys' (indexed by key code row*4+col).
module tb_keypad_scan_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] address;
  logic       chipselect, write_n, read_n;
  logic [7:0] writedata, readdata;
  logic [3:0] row_in, col_out;
  logic       irq;
  logic [15:0] keys;
  int n_cmp = 0;
  int n_bad = 0;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .row_in(row_in), .col_out(col_out), .irq(irq)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_out[c] && keys[r*4+c]) row_in[r] = 1'b0;
  end

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    #1 d = readdata;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic wait_not_empty(input string tag);
    logic [7:0] s;
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      bus_read(2'd1, s);
      if (s[0]) found = 1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL %s_event_timeout: status %h, want not_empty", tag, s); end
  endtask

  task automatic wait_scan_start();
    logic [3:0] prev;
    bit found = 0;
    @(negedge clk); prev = col_out;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (col_out == 4'b1110 && prev != 4'b1110) found = 1;
      prev = col_out;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL scan_start_timeout: col_out %b, want 1110 start", col_out); end
  endtask

  // Returns on the negedge of the first EMIT cycle (EMIT index 0).
  task automatic wait_emit_start();
    logic [3:0] p2, p1;
    bit found = 0;
    @(negedge clk); p2 = col_out;
    @(negedge clk); p1 = col_out;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (p2 == 4'b0111 && p1 == 4'b1111 && col_out == 4'b1111) found = 1;
      p2 = p1; p1 = col_out;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL emit_start_timeout: col_out %b, want EMIT", col_out); end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    n_cmp++;
    if (col_out !== 4'b1111) begin n_bad++; $display("FAIL reset_col_out: got %b want 1111", col_out); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      n_cmp++;
      if (d !== 8'h00) begin n_bad++; $display("FAIL reset_read_addr%0d: got %h want 00", a, d); end
    end
  endtask

  task automatic test_scan_steps();
    logic [3:0] exp_col [4];
    logic [7:0] d;
    bit found = 0;
    exp_col[0] = 4'b1110; exp_col[1] = 4'b1101; exp_col[2] = 4'b1011; exp_col[3] = 4'b0111;
    bus_write(2'd2, 8'h01);
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (col_out == 4'b1110) found = 1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL scan_enable_timeout: col_out %b want 1110", col_out); end
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (col_out !== exp_col[k/4]) begin
        n_bad++; $display("FAIL scan_step_%0d: got %b want %b", k, col_out, exp_col[k/4]);
      end
      @(negedge clk);
    end
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 8'h08) begin n_bad++; $display("FAIL scan_status: got %h want 08", d); end
  endtask

  task automatic test_single_press();
    logic [7:0] d;
    keys[9] = 1'b1;
    wait_not_empty("single");
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL single_irq_masked: got %b want 0", irq); end
    repeat (80) @(negedge clk);
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 8'h19) begin n_bad++; $display("FAIL single_status_once: got %h want 19", d); end
    bus_write(2'd2, 8'h03);
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL single_irq_on: got %b want 1", irq); end
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 8'h89) begin n_bad++; $display("FAIL single_data: got %h want 89", d); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL single_irq_after_pop: got %b want 0", irq); end
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL single_data_empty: got %h want 00", d); end
    keys[9] = 1'b0;
    repeat (100) @(negedge clk);
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 8'h08) begin n_bad++; $display("FAIL single_release_no_event: got %h want 08", d); end
  endtask

  task automatic test_bounce();
    logic [7:0] d;
    for (int k = 0; k < 5; k++) begin
      wait_scan_start();
      keys[5] = (k % 2 == 0);
    end
    wait_scan_start();
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 8'h08) begin n_bad++; $display("FAIL bounce_no_event: got %h want 08", d); end
    wait_not_empty("bounce");
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 8'h85) begin n_bad++; $display("FAIL bounce_data: got %h want 85", d); end
    repeat (60) @(negedge clk);
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 8'h08) begin n_bad++; $display("FAIL bounce_single_event: got %h want 08", d); end
    keys[5] = 1'b0;
    repeat (100) @(negedge clk);
  endtask

  task automatic test_two_keys();
    logic [7:0] d;
    bit found = 0;
    wait_scan_start();
    keys[0] = 1'b1; keys[15] = 1'b1;
    for (int i = 0; i < 300 && !found; i++) begin
      bus_read(2'd1, d);
      if (d[6:4] == 3'd2) found = 1;
    end
    n_cmp++;
    if (d !== 8'h29) begin n_bad++; $display("FAIL two_status: got %h want 29", d); end
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 8'h80) begin n_bad++; $display("FAIL two_first: got %h want 80", d); end
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 8'h8F) begin n_bad++; $display("FAIL two_second: got %h want 8f", d); end
    keys[0] = 1'b0; keys[15] = 1'b0;
    repeat (100) @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    int codes [5];
    logic [7:0] exp_tail [4];
    codes[0] = 1; codes[1] = 2; codes[2] = 3; codes[3] = 4; codes[4] = 6;
    exp_tail[0] = 8'h82; exp_tail[1] = 8'h83; exp_tail[2] = 8'h84; exp_tail[3] = 8'h87;
    for (int k = 0; k < 5; k++) begin
      keys[codes[k]] = 1'b1;
      repeat (100) @(negedge clk);
      keys[codes[k]] = 1'b0;
      repeat (100) @(negedge clk);
    end
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 8'h4F) begin n_bad++; $display("FAIL ovf_status: got %h want 4f", d); end
    bus_write(2'd1, 8'h04);
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 8'h4B) begin n_bad++; $display("FAIL ovf_clear: got %h want 4b", d); end
    // Code 7 is pushed during EMIT index 7; time a DATA pop onto that cycle.
    keys[7] = 1'b1;
    wait_emit_start();
    repeat (6) @(negedge clk);
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 8'h81) begin n_bad++; $display("FAIL ovf_pop_at_full: got %h want 81", d); end
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 8'h4B) begin n_bad++; $display("FAIL ovf_push_pop_full: got %h want 4b", d); end
    for (int k = 0; k < 4; k++) begin
      bus_read(2'd0, d);
      n_cmp++;
      if (d !== exp_tail[k]) begin n_bad++; $display("FAIL ovf_drain_%0d: got %h want %h", k, d, exp_tail[k]); end
    end
    keys[7] = 1'b0;
    repeat (100) @(negedge clk);
  endtask

  task automatic test_scan_disable();
    logic [7:0] d;
    bit found = 0;
    keys[10] = 1'b1;
    wait_not_empty("disable_first");
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL dis_irq_high: got %b want 1", irq); end
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 8'h8A) begin n_bad++; $display("FAIL dis_first_data: got %h want 8a", d); end
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (col_out == 4'b1101) found = 1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL dis_mid_column_timeout: col_out %b want 1101", col_out); end
    bus_write(2'd2, 8'h02);
    @(negedge clk);
    n_cmp++;
    if (col_out !== 4'b1111) begin n_bad++; $display("FAIL dis_col_idle: got %b want 1111", col_out); end
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 8'h00) begin n_bad++; $display("FAIL dis_status: got %h want 00", d); end
    bus_read(2'd2, d);
    n_cmp++;
    if (d !== 8'h02) begin n_bad++; $display("FAIL dis_control: got %h want 02", d); end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (col_out !== 4'b1111) begin n_bad++; $display("FAIL dis_col_stays: got %b want 1111", col_out); end
    bus_write(2'd2, 8'h03);
    wait_not_empty("reenable");
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 8'h8A) begin n_bad++; $display("FAIL dis_rereport: got %h want 8a", d); end
    repeat (100) @(negedge clk);
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 8'h08) begin n_bad++; $display("FAIL dis_rereport_once: got %h want 08", d); end
  endtask

  task automatic test_reset_mid_emit();
    logic [7:0] d;
    keys[10] = 1'b0;
    repeat (100) @(negedge clk);
    keys[0] = 1'b1; keys[12] = 1'b1;
    wait_emit_start();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL rst_pre_irq: got %b want 1", irq); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (col_out !== 4'b1111) begin n_bad++; $display("FAIL rst_async_col: got %b want 1111", col_out); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_async_irq: got %b want 0", irq); end
    keys = 16'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      n_cmp++;
      if (d !== 8'h00) begin n_bad++; $display("FAIL rst_read_addr%0d: got %h want 00", a, d); end
    end
    n_cmp++;
    if (col_out !== 4'b1111 || irq !== 1'b0) begin
      n_bad++; $display("FAIL rst_outputs: col_out %b irq %b want 1111 0", col_out, irq);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; keys = 16'h0;
    address = 2'd0; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; writedata = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    test_reset();
    test_scan_steps();
    test_single_press();
    test_bounce();
    test_two_keys();
    test_overflow();
    test_scan_disable();
    test_reset_mid_emit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Avalon-MM slave that autonomously scans a 4x4 active-low matrix keypad by driving the column lines, sampling the rows, debouncing, and queuing press events as 4-bit key codes in a small FIFO with a level interrupt. It replaces software column strobing through a plain output PIO: the CPU only enables scanning and pops key codes.

## Interface
Parameters:
- SCAN_DIV, 1000: clocks per column step; must be >= 4.
- DEBOUNCE, 3: consecutive identical full scans required to accept a keypad state; 1..15.
- FIFO_DEPTH, 4: key-event FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; zero wait states.
- read_n  in  1  active-low read strobe; zero wait states; pops DATA.
- writedata  in  8  write data.
- readdata  out  8  read data; combinational mux of registers.
- row_in  in  4  keypad rows; active-low, externally pulled up; asynchronous.
- col_out  out  4  keypad columns; one column driven low while scanning.
- irq  out  1  level interrupt.

## Operation
- Register map:
  - addr 0 DATA (R): bit7 valid (FIFO non-empty), bits[3:0] head key code, other bits 0. A read with chipselect & ~read_n & non-empty pops one entry. Write ignored.
  - addr 1 STATUS (R): bit0 not_empty, bit1 full, bit2 overflow (sticky), bit3 scan_en, bits[6:4] entry count (saturates at 7). Writing 1 to bit2 clears overflow.
  - addr 2 CONTROL (R/W): bit0 scan_en, bit1 irq_en. Writing 1 to bit2 flushes the FIFO; bit2 reads 0.
  - addr 3: reads 0; writes ignored.
- row_in passes through a 2-flop synchronizer before use.
- FSM states:
  - IDLE: col_out = 4'b1111. Moves to SCAN when scan_en = 1, starting at col 0.
  - SCAN: col_out = ~(4'b0001 << col). The step counter runs 0..SCAN_DIV-1. At count SCAN_DIV-1, synchronized rows are latched into snapshot bits [col*4 +: 4] as pressed = ~row, then col increments. After col 3, go to CMP.
  - CMP (1 cycle): if snapshot == prev_snapshot, stable_cnt increments (saturating); otherwise stable_cnt = 0. prev_snapshot <= snapshot. When stable_cnt reaches DEBOUNCE-1 on an equal compare, accepted <= snapshot and new_mask <= snapshot & ~accepted. Go to EMIT if new_mask != 0, else SCAN col 0.
  - EMIT (16 cycles): at index i = 0..15, if new_mask[i] then push key code i = row*4 + col (bit index = col*4 + row; code = {row, col}). col_out = 4'b1111. Then SCAN col 0.
- Key releases update accepted but generate no event.
- Clearing scan_en in any state returns the FSM to IDLE on the next clock. On that transition, col, step counter, stable_cnt, snapshot, prev_snapshot and accepted all clear to 0. FIFO contents are kept.
- FIFO rules:
  - Push when full: entry dropped, overflow set.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Pop when empty: ignored; readdata = 0.
  - Push and pop in the same cycle while empty: push succeeds; the read returns valid = 0.
  - Flush in the same cycle as a push: flush wins, FIFO empty.
- irq = irq_en & not_empty, driven from registered state.

## Timing
- Reset values:
  - col_out 4'b1111; irq 0; readdata 0 (FIFO empty).
  - scan_en, irq_en, overflow 0; FSM IDLE; all counters and masks 0.
- Register writes take effect on the next clock edge. readdata is valid in the same cycle as address.
- Pop takes effect at the clock edge ending the read cycle; the next read sees the next entry.
- One full scan = 4*SCAN_DIV + 1 cycles, plus 16 when EMIT runs.
- Press-to-FIFO latency: at most (DEBOUNCE + 1) scans + 16 cycles; irq rises 1 cycle after the push.
- Row sampling occurs SCAN_DIV-1 cycles after the column switch. The synchronizer adds 2 cycles, so rows have settled by sampling time.

## Test plan
Use SCAN_DIV = 4 and DEBOUNCE = 2 unless noted.
- Reset: then read all addresses -> readdata 0, col_out 4'b1111, irq 0. Write CONTROL = 8'h01 -> col_out steps 1110, 1101, 1011, 0111, 4 clocks each.
- Single press at row 2, col 1, held -> exactly one push of code 4'h9. DATA reads 8'h89, then 8'h00 after the pop. irq is high only while irq_en = 1 and the FIFO is non-empty.
- Bounce: key toggles every scan for 5 scans, then holds -> no event during bouncing, exactly one event after 2 stable scans.
- Two keys (code 0 and code 15) pressed in the same scan -> both pushed in EMIT order 0 then 15; count = 2.
- Overflow, FIFO_DEPTH = 4: 5 distinct press/release events with no reads -> full = 1, overflow = 1, first 4 codes retained. Writing STATUS bit2 = 1 clears overflow. Simultaneous pop + push at full -> no overflow.
- Clear scan_en mid-column, then re-enable while a key is held -> col_out = 1111 the next cycle. After re-enable the held key is reported again once. Asserting reset_n mid-EMIT -> all reset values restored.
